// File: rtl/alu_exec_defs.sv
// Shared definitions for the alu_exec_unit execute block: opcodes, FSM state
// encoding, flag bit positions and iterative-datapath mode encoding.
package alu_exec_defs;

   localparam logic [3:0] OpNop = 4'h0;
   localparam logic [3:0] OpAdd = 4'h1;
   localparam logic [3:0] OpSub = 4'h2;
   localparam logic [3:0] OpMul = 4'h3;
   localparam logic [3:0] OpAnd = 4'h4;
   localparam logic [3:0] OpOr  = 4'h5;
   localparam logic [3:0] OpXor = 4'h6;
   localparam logic [3:0] OpShl = 4'h7;
   localparam logic [3:0] OpShr = 4'h8;
   localparam logic [3:0] OpCmp = 4'h9;
   localparam logic [3:0] OpDiv = 4'hA;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
      StDiv  = 2'd2,
      StDone = 2'd3
   } state_e;

   // Bit positions inside the {Z,N,C,V} flag vector
   localparam int unsigned FlagZ = 3;
   localparam int unsigned FlagN = 2;
   localparam int unsigned FlagC = 1;
   localparam int unsigned FlagV = 0;

   localparam logic IterMul = 1'b0;
   localparam logic IterDiv = 1'b1;

endpackage

// File: rtl/alu_exec_iter.sv
// Shared shift/accumulate datapath for the multi-cycle ops: shift-add
// multiplier and (when ALU_EXEC_DIV_EN is defined) restoring divider.
// done_o is high during the final iteration; lo_o/hi_o then present the
// finished result so the caller can register it on that same edge.
module alu_exec_iter
   import alu_exec_defs::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              mode_i,
   input  logic [DATA_W-1:0] op_a_i,
   input  logic [DATA_W-1:0] op_b_i,
   output logic              done_o,
   output logic [DATA_W-1:0] lo_o,
   output logic [DATA_W-1:0] hi_o
);

   localparam int unsigned CntW = $clog2(DATA_W);

   // hi: partial product / partial remainder; lo: multiplier / dividend-quotient
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic [DATA_W-1:0] opnd_q, opnd_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic [DATA_W-1:0] step_hi, step_lo;
   logic [DATA_W:0]   mul_sum;

`ifdef ALU_EXEC_DIV_EN
   logic              mode_q, mode_d;
   logic [DATA_W:0]   div_shift;
   logic [DATA_W+1:0] div_trial;
   logic              unused_trial;
   // A non-negative trial is always below the divisor, so its bit DATA_W is zero
   assign unused_trial = div_trial[DATA_W];
`else
   logic              unused_mode;
   assign unused_mode = mode_i;
`endif

   assign done_o = busy_q && (cnt_q == CntW'(DATA_W - 1));
   assign lo_o   = step_lo;
   assign hi_o   = step_hi;

   // One iteration of the selected algorithm
   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], lo_q[DATA_W-1:1]};
`ifdef ALU_EXEC_DIV_EN
      div_shift = {hi_q, lo_q[DATA_W-1]};
      div_trial = {1'b0, div_shift} - {2'b00, opnd_q};
      if (mode_q == IterDiv) begin
         if (div_trial[DATA_W+1]) begin
            step_hi = div_shift[DATA_W-1:0];
            step_lo = {lo_q[DATA_W-2:0], 1'b0};
         end else begin
            step_hi = div_trial[DATA_W-1:0];
            step_lo = {lo_q[DATA_W-2:0], 1'b1};
         end
      end
`endif
   end

   // Load on start, then iterate DATA_W times
   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      opnd_d = opnd_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
`ifdef ALU_EXEC_DIV_EN
      mode_d = mode_q;
`endif
      if (start_i) begin
         hi_d   = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
`ifdef ALU_EXEC_DIV_EN
         mode_d = mode_i;
         if (mode_i == IterDiv) begin
            lo_d   = op_a_i;
            opnd_d = op_b_i;
         end else begin
            lo_d   = op_b_i;
            opnd_d = op_a_i;
         end
`else
         lo_d   = op_b_i;
         opnd_d = op_a_i;
`endif
      end else if (busy_q) begin
         hi_d   = step_hi;
         lo_d   = step_lo;
         cnt_d  = cnt_q + 1'b1;
         busy_d = !done_o;
      end
   end

   // Datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hi_q   <= '0;
         lo_q   <= '0;
         opnd_q <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
`ifdef ALU_EXEC_DIV_EN
         mode_q <= IterMul;
`endif
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         opnd_q <= opnd_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
`ifdef ALU_EXEC_DIV_EN
         mode_q <= mode_d;
`endif
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Valid/ready handshaked execute unit. Single-cycle ops complete in one cycle;
// MUL (and DIV when ALU_EXEC_DIV_EN is defined) run DATA_W cycles through
// alu_exec_iter. Results are held in DONE until write-back accepts them.
module alu_exec_unit
   import alu_exec_defs::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned TAG_W  = 8
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              iValid,
   output logic              oReady,
   input  logic [3:0]        iOperation,
   input  logic [DATA_W-1:0] iOperandA,
   input  logic [DATA_W-1:0] iOperandB,
   input  logic [TAG_W-1:0]  iDestination,
   output logic              oValid,
   input  logic              iReady,
   output logic [DATA_W-1:0] oResult,
   output logic [DATA_W-1:0] oResultHi,
   output logic [TAG_W-1:0]  oDestination,
   output logic              oWriteEnable,
   output logic [3:0]        oFlags,
   output logic              oIllegal
);

   localparam int unsigned ShW = $clog2(DATA_W);
   localparam int unsigned Msb = DATA_W - 1;

   state_e            state_q, state_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [DATA_W-1:0] result_hi_q, result_hi_d;
   logic [TAG_W-1:0]  dest_q, dest_d;
   logic              we_q, we_d;
   logic [3:0]        flags_q, flags_d;
   logic              illegal_q, illegal_d;

   logic              accept;
   logic              iter_start, iter_mode, iter_done;
   logic [DATA_W-1:0] iter_lo, iter_hi;

   logic [DATA_W-1:0] sc_result;
   logic [3:0]        sc_flags;
   logic              sc_we, sc_illegal, sc_c, sc_v, sc_upd;
   logic [ShW-1:0]    shamt;
   logic [DATA_W:0]   sum_ext, diff_ext, shl_ext, shr_ext;

`ifdef ALU_EXEC_DIV_EN
   logic              dvz_q, dvz_d;
`endif

   assign oReady       = (state_q == StIdle) || ((state_q == StDone) && iReady);
   assign accept       = iValid && oReady;
   assign oValid       = valid_q;
   assign oResult      = result_q;
   assign oResultHi    = result_hi_q;
   assign oDestination = dest_q;
   assign oWriteEnable = we_q;
   assign oFlags       = flags_q;
   assign oIllegal     = illegal_q;

   alu_exec_iter #(
      .DATA_W(DATA_W)
   ) u_iter (
      .clk_i  (Clock),
      .rst_ni (Reset),
      .start_i(iter_start),
      .mode_i (iter_mode),
      .op_a_i (iOperandA),
      .op_b_i (iOperandB),
      .done_o (iter_done),
      .lo_o   (iter_lo),
      .hi_o   (iter_hi)
   );

   // Single-cycle result and flags from the presented operands
   always_comb begin
      sc_result  = '0;
      sc_flags   = flags_q;
      sc_we      = 1'b0;
      sc_illegal = 1'b0;
      sc_c       = 1'b0;
      sc_v       = 1'b0;
      sc_upd     = 1'b1;
      shamt      = iOperandB[ShW-1:0];
      sum_ext    = {1'b0, iOperandA} + {1'b0, iOperandB};
      diff_ext   = {1'b0, iOperandA} - {1'b0, iOperandB};
      // Extra bit catches the last bit shifted out; zero for a zero amount
      shl_ext    = {1'b0, iOperandA} << shamt;
      shr_ext    = {iOperandA, 1'b0} >> shamt;
      case (iOperation)
         OpNop: sc_upd = 1'b0;
         OpAdd: begin
            sc_result = sum_ext[DATA_W-1:0];
            sc_c      = sum_ext[DATA_W];
            sc_v      = (iOperandA[Msb] == iOperandB[Msb]) && (sum_ext[Msb] != iOperandA[Msb]);
            sc_we     = 1'b1;
         end
         OpSub, OpCmp: begin
            sc_result = diff_ext[DATA_W-1:0];
            sc_c      = diff_ext[DATA_W];
            sc_v      = (iOperandA[Msb] != iOperandB[Msb]) && (diff_ext[Msb] != iOperandA[Msb]);
            sc_we     = (iOperation == OpSub);
         end
         OpAnd: begin
            sc_result = iOperandA & iOperandB;
            sc_we     = 1'b1;
         end
         OpOr: begin
            sc_result = iOperandA | iOperandB;
            sc_we     = 1'b1;
         end
         OpXor: begin
            sc_result = iOperandA ^ iOperandB;
            sc_we     = 1'b1;
         end
         OpShl: begin
            sc_result = shl_ext[DATA_W-1:0];
            sc_c      = shl_ext[DATA_W];
            sc_we     = 1'b1;
         end
         OpShr: begin
            sc_result = shr_ext[DATA_W:1];
            sc_c      = shr_ext[0];
            sc_we     = 1'b1;
         end
         default: begin
            sc_upd     = 1'b0;
            sc_illegal = 1'b1;
         end
      endcase
      if (sc_upd) begin
         sc_flags[FlagZ] = (sc_result == '0);
         sc_flags[FlagN] = sc_result[Msb];
         sc_flags[FlagC] = sc_c;
         sc_flags[FlagV] = sc_v;
      end
   end

   // Next state: dispatch on accept, capture multi-cycle results, retire on iReady
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      dest_d      = dest_q;
      we_d        = we_q;
      flags_d     = flags_q;
      illegal_d   = illegal_q;
      iter_start  = 1'b0;
      iter_mode   = IterMul;
`ifdef ALU_EXEC_DIV_EN
      dvz_d       = dvz_q;
`endif

      if ((state_q == StDone) && iReady) begin
         valid_d = 1'b0;
         state_d = StIdle;
      end

      if (accept) begin
         dest_d = iDestination;
         if (iOperation == OpMul) begin
            iter_start = 1'b1;
            iter_mode  = IterMul;
            valid_d    = 1'b0;
            state_d    = StMul;
         end
`ifdef ALU_EXEC_DIV_EN
         else if (iOperation == OpDiv) begin
            iter_start = 1'b1;
            iter_mode  = IterDiv;
            dvz_d      = (iOperandB == '0);
            valid_d    = 1'b0;
            state_d    = StDiv;
         end
`endif
         else begin
            result_d    = sc_result;
            result_hi_d = '0;
            we_d        = sc_we;
            flags_d     = sc_flags;
            illegal_d   = sc_illegal;
            valid_d     = 1'b1;
            state_d     = StDone;
         end
      end

      if ((state_q == StMul) && iter_done) begin
         result_d       = iter_lo;
         result_hi_d    = iter_hi;
         we_d           = 1'b1;
         illegal_d      = 1'b0;
         flags_d[FlagZ] = ({iter_hi, iter_lo} == '0);
         flags_d[FlagN] = iter_lo[Msb];
         flags_d[FlagC] = (iter_hi != '0);
         flags_d[FlagV] = 1'b0;
         valid_d        = 1'b1;
         state_d        = StDone;
      end

`ifdef ALU_EXEC_DIV_EN
      if ((state_q == StDiv) && iter_done) begin
         result_d       = iter_lo;
         result_hi_d    = iter_hi;
         we_d           = 1'b1;
         illegal_d      = 1'b0;
         flags_d[FlagZ] = (iter_lo == '0);
         flags_d[FlagN] = iter_lo[Msb];
         flags_d[FlagC] = 1'b0;
         flags_d[FlagV] = dvz_q;
         valid_d        = 1'b1;
         state_d        = StDone;
      end
`endif
   end

   // State and registered outputs
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q     <= StIdle;
         valid_q     <= 1'b0;
         result_q    <= '0;
         result_hi_q <= '0;
         dest_q      <= '0;
         we_q        <= 1'b0;
         flags_q     <= '0;
         illegal_q   <= 1'b0;
`ifdef ALU_EXEC_DIV_EN
         dvz_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         dest_q      <= dest_d;
         we_q        <= we_d;
         flags_q     <= flags_d;
         illegal_q   <= illegal_d;
`ifdef ALU_EXEC_DIV_EN
         dvz_q       <= dvz_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed, table-driven bench for alu_exec_unit (DATA_W=16, TAG_W=8) plus
// hand-written sequences for busy/stall/back-to-back and reset-abort cases.
module tb_alu_exec_unit;

   logic        Clock;
   logic        Reset;
   logic        iValid;
   logic        oReady;
   logic [3:0]  iOperation;
   logic [15:0] iOperandA;
   logic [15:0] iOperandB;
   logic [7:0]  iDestination;
   logic        oValid;
   logic        iReady;
   logic [15:0] oResult;
   logic [15:0] oResultHi;
   logic [7:0]  oDestination;
   logic        oWriteEnable;
   logic [3:0]  oFlags;
   logic        oIllegal;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [15:0] hi;
      logic [3:0]  flags;
      logic        we;
      logic        ill;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   alu_exec_unit #(
      .DATA_W(16),
      .TAG_W (8)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .iValid      (iValid),
      .oReady      (oReady),
      .iOperation  (iOperation),
      .iOperandA   (iOperandA),
      .iOperandB   (iOperandB),
      .iDestination(iDestination),
      .oValid      (oValid),
      .iReady      (iReady),
      .oResult     (oResult),
      .oResultHi   (oResultHi),
      .oDestination(oDestination),
      .oWriteEnable(oWriteEnable),
      .oFlags      (oFlags),
      .oIllegal    (oIllegal)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] res, input logic [15:0] hi, input logic [3:0] fl,
                          input logic we, input logic ill, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.res = res; v.hi = hi;
      v.flags = fl; v.we = we; v.ill = ill; v.lat = lat;
      vecs.push_back(v);
   endtask

   // Present one op, then count cycles until oValid (bounded)
   task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] d, output int lat);
      @(negedge Clock);
      iValid = 1'b1; iOperation = op; iOperandA = a; iOperandB = b; iDestination = d;
      @(posedge Clock);
      #1;
      iValid = 1'b0; iOperation = 4'h1; iOperandA = 16'hA5A5; iOperandB = 16'h5A5A;
      iDestination = 8'hEE;
      lat = 1;
      while (!oValid && lat < 200) begin
         @(posedge Clock);
         #1;
         lat++;
      end
   endtask

   task automatic retire(input string name);
      @(negedge Clock);
      iReady = 1'b1;
      @(posedge Clock);
      #1;
      iReady = 1'b0;
      check(name, {31'd0, oValid}, 32'd0);
   endtask

   initial begin
      int lat;
      logic busy_ok;

      // flags are {Z,N,C,V}
      add_vec(4'h1, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b0101, 1, 0, 1);
      add_vec(4'h2, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 4'b0110, 1, 0, 1);
      add_vec(4'h9, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 4'b1000, 0, 0, 1);
      add_vec(4'h9, 16'h0002, 16'h0007, 16'hFFFB, 16'h0000, 4'b0110, 0, 0, 1);
      add_vec(4'h0, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 4'b0110, 0, 0, 1);
      add_vec(4'h4, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 4'b0000, 1, 0, 1);
      add_vec(4'h5, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1000, 1, 0, 1);
      add_vec(4'h6, 16'hFFFF, 16'h0F0F, 16'hF0F0, 16'h0000, 4'b0100, 1, 0, 1);
      add_vec(4'h7, 16'h8001, 16'h0001, 16'h0002, 16'h0000, 4'b0010, 1, 0, 1);
      add_vec(4'h7, 16'h1234, 16'h0010, 16'h1234, 16'h0000, 4'b0000, 1, 0, 1);
      add_vec(4'h8, 16'h0003, 16'h0001, 16'h0001, 16'h0000, 4'b0010, 1, 0, 1);
      add_vec(4'h8, 16'h8000, 16'h000F, 16'h0001, 16'h0000, 4'b0000, 1, 0, 1);
      add_vec(4'h1, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b1010, 1, 0, 1);
      add_vec(4'h2, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0001, 1, 0, 1);
      add_vec(4'hF, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 4'b0001, 0, 1, 1);
      add_vec(4'hB, 16'h3333, 16'h4444, 16'h0000, 16'h0000, 4'b0001, 0, 1, 1);
      add_vec(4'h3, 16'h1234, 16'h5678, 16'h0060, 16'h0626, 4'b0010, 1, 0, 17);
      add_vec(4'h3, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 4'b1000, 1, 0, 17);
      add_vec(4'h3, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0010, 1, 0, 17);
      add_vec(4'h1, 16'h0001, 16'h0001, 16'h0002, 16'h0000, 4'b0000, 1, 0, 1);
`ifdef ALU_EXEC_DIV_EN
      add_vec(4'hA, 16'd100,  16'd7,    16'd14,   16'd2,    4'b0000, 1, 0, 17);
      add_vec(4'hA, 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 4'b0101, 1, 0, 17);
`else
      add_vec(4'hA, 16'd100,  16'd7,    16'h0000, 16'h0000, 4'b0000, 0, 1, 1);
      add_vec(4'hA, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 0, 1, 1);
`endif

      Reset = 1'b0; iValid = 1'b0; iReady = 1'b0; iOperation = 4'h0;
      iOperandA = '0; iOperandB = '0; iDestination = '0;
      #3;
      check("reset_valid", {31'd0, oValid}, 32'd0);
      check("reset_ready", {31'd0, oReady}, 32'd1);
      check("reset_outs", {oResult, oResultHi}, 32'd0);
      check("reset_misc", {19'd0, oDestination, oWriteEnable, oFlags, oIllegal}, 32'd0);
      @(negedge Clock);
      Reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, 8'(i + 1), lat);
         check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("v%0d_result", i), {16'd0, oResult}, {16'd0, vecs[i].res});
         check($sformatf("v%0d_result_hi", i), {16'd0, oResultHi}, {16'd0, vecs[i].hi});
         check($sformatf("v%0d_flags", i), {28'd0, oFlags}, {28'd0, vecs[i].flags});
         check($sformatf("v%0d_we", i), {31'd0, oWriteEnable}, {31'd0, vecs[i].we});
         check($sformatf("v%0d_illegal", i), {31'd0, oIllegal}, {31'd0, vecs[i].ill});
         check($sformatf("v%0d_dest", i), {24'd0, oDestination}, i + 1);
         retire($sformatf("v%0d_retire", i));
      end

      // MUL with a pending op held during busy, stall in DONE, then back-to-back accept
      @(negedge Clock);
      iValid = 1'b1; iOperation = 4'h3; iOperandA = 16'd3; iOperandB = 16'd4;
      iDestination = 8'h55;
      @(posedge Clock);
      #1;
      iOperation = 4'h1; iOperandA = 16'd2; iOperandB = 16'd3; iDestination = 8'h66;
      busy_ok = 1'b1;
      lat = 1;
      while (!oValid && lat < 200) begin
         if (oReady) busy_ok = 1'b0;
         @(posedge Clock);
         #1;
         lat++;
      end
      check("busy_oready_low", {31'd0, busy_ok}, 32'd1);
      check("busy_mul_latency", lat, 17);
      for (int k = 0; k < 5; k++) begin
         @(posedge Clock);
         #1;
         check($sformatf("stall%0d_hold", k),
               {oValid, oReady, oWriteEnable, 5'd0, oDestination, oResult},
               {1'b1, 1'b0, 1'b1, 5'd0, 8'h55, 16'd12});
      end
      @(negedge Clock);
      iReady = 1'b1;
      @(posedge Clock);
      #1;
      iValid = 1'b0;
      check("b2b_valid", {31'd0, oValid}, 32'd1);
      check("b2b_result", {8'd0, oDestination, oResult}, {8'd0, 8'h66, 16'd5});
      @(posedge Clock);
      #1;
      iReady = 1'b0;
      check("b2b_retire", {31'd0, oValid}, 32'd0);

      // Reset in the middle of a MUL aborts it
      @(negedge Clock);
      iValid = 1'b1; iOperation = 4'h3; iOperandA = 16'h1234; iOperandB = 16'h5678;
      iDestination = 8'h77;
      @(posedge Clock);
      #1;
      iValid = 1'b0;
      repeat (7) @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      #1;
      check("midreset_valid", {31'd0, oValid}, 32'd0);
      check("midreset_ready", {31'd0, oReady}, 32'd1);
      check("midreset_outs", {oResult, oResultHi}, 32'd0);
      check("midreset_misc", {19'd0, oDestination, oWriteEnable, oFlags, oIllegal}, 32'd0);
      @(negedge Clock);
      Reset = 1'b1;
      busy_ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge Clock);
         #1;
         if (oValid) busy_ok = 1'b0;
      end
      check("midreset_no_result", {31'd0, busy_ok}, 32'd1);
      issue(4'h1, 16'd2, 16'd2, 8'h12, lat);
      check("post_reset_latency", lat, 1);
      check("post_reset_add", {8'd0, oDestination, oResult}, {8'd0, 8'h12, 16'd4});
      check("post_reset_flags", {28'd0, oFlags}, 32'd0);
      retire("post_reset_retire");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised multi-cycle execute unit for the MiniAlu-family processor. It sits between operand read (data RAM ports) and register write-back, and replaces the single-cycle combinational ALU case with a valid/ready-handshaked unit. Single-cycle ops complete in one cycle; MUL (and optional DIV) iterate over DATA_W cycles. Results carry their destination tag so write-back can stall cleanly.

## Interface
- DATA_W, 16, operand/result width (≥4, power of two)
- TAG_W, 8, destination-address tag width
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- iValid  in  1  upstream operation valid
- oReady  out  1  unit can accept an operation this cycle
- iOperation  in  4  opcode
- iOperandA  in  DATA_W  first operand (SourceData1)
- iOperandB  in  DATA_W  second operand (SourceData0)
- iDestination  in  TAG_W  write-back tag
- oValid  out  1  result valid
- iReady  in  1  write-back accepts result
- oResult  out  DATA_W  result (low half for MUL, quotient for DIV)
- oResultHi  out  DATA_W  MUL high half / DIV remainder, else 0
- oDestination  out  TAG_W  tag of the result
- oWriteEnable  out  1  result must be written back
- oFlags  out  4  {Z,N,C,V}
- oIllegal  out  1  completed op had an undefined opcode

## Operation
- Opcodes: NOP 0, ADD 1, SUB 2, MUL 3, AND 4, OR 5, XOR 6, SHL 7, SHR 8, CMP 9, DIV A (macro only); B–F illegal.
- States: IDLE, MUL, DIV, DONE. Transfer in = iValid & oReady; transfer out = oValid & iReady.
- IDLE: accept → single-cycle ops compute, register outputs, go DONE; MUL → MUL; DIV → DIV.
- MUL: shift-add, one bit of iOperandB per cycle, DATA_W cycles, then DONE. 2·DATA_W-bit product on {oResultHi,oResult}.
- DIV: restoring, DATA_W cycles, then DONE. Divide by zero: quotient all-ones, remainder = A, V=1.
- DONE: oValid=1, outputs held stable until iReady. oReady = IDLE | (DONE & iReady); a new op accepted on the same edge as the output transfer (back-to-back). Operands latched at acceptance; inputs ignored afterwards.
- ADD: A+B, C carry-out, V signed overflow. SUB/CMP: A−B, C = borrow (A<B unsigned), V signed overflow; CMP has oWriteEnable=0. So A≤B unsigned ⇔ Z|C.
- AND/OR/XOR: C=V=0. SHL/SHR (logical): amount B[log2(DATA_W)-1:0]; C = last bit shifted out, C=0 for amount 0; V=0.
- MUL: Z = full product zero, N = oResult msb, C = (oResultHi≠0), V=0.
- Z/N computed on oResult for all other ops. NOP and illegal: oWriteEnable=0, oResult=0, flags hold previous value; illegal sets oIllegal=1.
- oResultHi=0 except MUL/DIV.

## Timing
- Reset (async assert, sync deassert by system): state IDLE, oValid=0, oResult=oResultHi=0, oDestination=0, oWriteEnable=0, oFlags=0, oIllegal=0. Reset mid-MUL/DIV aborts; no result emitted.
- Latency acceptance→oValid: 1 cycle single-cycle ops; DATA_W+1 cycles MUL/DIV.
- oReady is combinational from state and iReady; all other outputs registered.
- Stall in DONE indefinitely without loss; iValid during MUL/DIV sees oReady=0.

## Configuration
- ALU_EXEC_DIV_EN defined: DIV state and restoring divider present, opcode A legal.
- Undefined: no divider logic; opcode A is illegal (oIllegal=1, no write).

## Structure
- Shared definitions package alu_exec_defs: opcode constants, state encoding, flag bit indices (Z=3,N=2,C=1,V=0).
- One sub-module: alu_exec_iter, the shared shift/accumulate datapath used by MUL and DIV (start, done, mode inputs).

## Test plan
- ADD 0x7FFF+0x0001 (DATA_W=16) → oResult 0x8000, flags N=1,V=1,C=0,Z=0, oValid 1 cycle after accept.
- SUB 3−5 then CMP 5,5 → 0xFFFE with C=1,N=1; CMP: Z=1, oWriteEnable=0.
- MUL 0x1234×0x5678 → {oResultHi,oResult}=0x0626_0060, C=1, oValid exactly 17 cycles after accept; iValid during busy not accepted.
- Hold iReady=0 for 5 cycles in DONE, then iReady=1 with iValid=1 → outputs stable throughout, new op accepted same edge, no bubble.
- Assert Reset low mid-MUL (cycle 8) → all outputs 0 immediately, state IDLE; next ADD 2+2 → 4.
- Opcode 0xA with ALU_EXEC_DIV_EN: 100÷7 → 14 rem 2 after 17 cycles; 5÷0 → 0xFFFF, rem 5, V=1; without macro → oIllegal=1, oWriteEnable=0.
